// File: rtl/cell_comm_pkg.sv
// Shared types and helpers for the Aurora cell-comm TX arbiter.
package cell_comm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    localparam logic SRC_LOCAL = 1'b0;
    localparam logic SRC_FWD   = 1'b1;

    // Bits needed to hold a word index 0..n-1 (at least one bit).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w = 1;
        while ((64'(1) << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/cell_comm_tx_arbiter_if.sv
// AXIS bundle for the two packet sources and the shared Aurora TX link.
interface cell_comm_tx_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  localTvalid;
    logic                  localTlast;
    logic [DATA_WIDTH-1:0] localTdata;
    logic                  localTready;

    logic                  fwdTvalid;
    logic                  fwdTlast;
    logic [DATA_WIDTH-1:0] fwdTdata;
    logic                  fwdTready;

    logic                  txTvalid;
    logic                  txTlast;
    logic [DATA_WIDTH-1:0] txTdata;
    logic                  txTready;

    modport master (
        input  localTvalid, localTlast, localTdata,
        output localTready,
        input  fwdTvalid, fwdTlast, fwdTdata,
        output fwdTready,
        output txTvalid, txTlast, txTdata,
        input  txTready
    );

    modport slave (
        output localTvalid, localTlast, localTdata,
        input  localTready,
        output fwdTvalid, fwdTlast, fwdTdata,
        input  fwdTready,
        input  txTvalid, txTlast, txTdata,
        output txTready
    );
endinterface

// File: rtl/cell_comm_stat_counters.sv
// Four free-running wrap-around packet statistics counters for the CSR.
module cell_comm_stat_counters #(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_local,
    input  logic                     inc_fwd,
    input  logic                     inc_drop,
    input  logic                     inc_trunc,
    output logic [COUNTER_WIDTH-1:0] local_count,
    output logic [COUNTER_WIDTH-1:0] fwd_count,
    output logic [COUNTER_WIDTH-1:0] drop_count,
    output logic [COUNTER_WIDTH-1:0] trunc_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            local_count <= '0;
            fwd_count   <= '0;
            drop_count  <= '0;
            trunc_count <= '0;
        end else begin
            if (inc_local) local_count <= local_count + COUNTER_WIDTH'(1);
            if (inc_fwd)   fwd_count   <= fwd_count   + COUNTER_WIDTH'(1);
            if (inc_drop)  drop_count  <= drop_count  + COUNTER_WIDTH'(1);
            if (inc_trunc) trunc_count <= trunc_count + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cell_comm_tx_arbiter.sv
// Per-packet round-robin arbiter sharing one Aurora TX AXIS link between the
// LOCAL and FWD sources, with channel-down dropping and runaway truncation.
module cell_comm_tx_arbiter
    import cell_comm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_PKT_WORDS = 64,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     auroraUserClk,
    input  logic                     auroraUserResetN,
    input  logic                     channelUp,
    cell_comm_tx_arbiter_if.master   bus,
    output logic                     busy,
    output logic                     grantFwd,
    output logic [COUNTER_WIDTH-1:0] localPktCount,
    output logic [COUNTER_WIDTH-1:0] fwdPktCount,
    output logic [COUNTER_WIDTH-1:0] dropCount,
    output logic [COUNTER_WIDTH-1:0] truncCount
);

    localparam int unsigned    CNT_W    = clog2(MAX_PKT_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_WORDS - 1);

    state_e             state, state_nxt;
    logic               grant, grant_nxt;
    logic [CNT_W-1:0]   word_cnt, word_cnt_nxt;
    logic               inc_local, inc_fwd, inc_drop, inc_trunc;
    logic               sel_valid, sel_last, at_limit;
    logic [DATA_WIDTH-1:0] sel_data;

    // Datapath follows the registered grant, so PASS forwards with no added latency.
    assign sel_valid = (grant == SRC_FWD) ? bus.fwdTvalid : bus.localTvalid;
    assign sel_last  = (grant == SRC_FWD) ? bus.fwdTlast  : bus.localTlast;
    assign sel_data  = (grant == SRC_FWD) ? bus.fwdTdata  : bus.localTdata;
    assign at_limit  = (word_cnt == LAST_IDX);

    always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
        if (!auroraUserResetN) begin
            state    <= IDLE;
            grant    <= SRC_FWD;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        word_cnt_nxt    = word_cnt;
        inc_local       = 1'b0;
        inc_fwd         = 1'b0;
        inc_drop        = 1'b0;
        inc_trunc       = 1'b0;
        bus.txTvalid    = 1'b0;
        bus.txTlast     = 1'b0;
        bus.txTdata     = '0;
        bus.localTready = 1'b0;
        bus.fwdTready   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.localTvalid || bus.fwdTvalid) begin
                    grant_nxt = (bus.localTvalid && bus.fwdTvalid) ? ~grant : bus.fwdTvalid;
                    if (channelUp) begin
                        state_nxt = PASS;
                    end else begin
                        state_nxt = DISCARD;
                        inc_drop  = 1'b1;
                    end
                end
            end

            PASS: begin
                // Channel loss gates the link at once; Aurora drops the partial frame.
                if (!channelUp) begin
                    inc_drop     = 1'b1;
                    word_cnt_nxt = '0;
                    state_nxt    = DISCARD;
                end else begin
                    bus.txTvalid = sel_valid;
                    bus.txTdata  = sel_data;
                    bus.txTlast  = sel_last || at_limit;
                    if (grant == SRC_FWD) bus.fwdTready   = bus.txTready;
                    else                  bus.localTready = bus.txTready;
                    if (sel_valid && bus.txTready) begin
                        if (sel_last) begin
                            inc_fwd      = (grant == SRC_FWD);
                            inc_local    = (grant == SRC_LOCAL);
                            word_cnt_nxt = '0;
                            state_nxt    = IDLE;
                        end else if (at_limit) begin
                            inc_trunc    = 1'b1;
                            word_cnt_nxt = '0;
                            state_nxt    = DISCARD;
                        end else begin
                            word_cnt_nxt = word_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            DISCARD: begin
                if (grant == SRC_FWD) bus.fwdTready   = 1'b1;
                else                  bus.localTready = 1'b1;
                if (sel_valid && sel_last) state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign grantFwd = grant;

    cell_comm_stat_counters #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_stats (
        .clk         (auroraUserClk),
        .rst_n       (auroraUserResetN),
        .inc_local   (inc_local),
        .inc_fwd     (inc_fwd),
        .inc_drop    (inc_drop),
        .inc_trunc   (inc_trunc),
        .local_count (localPktCount),
        .fwd_count   (fwdPktCount),
        .drop_count  (dropCount),
        .trunc_count (truncCount)
    );

endmodule

// File: tb/tb_cell_comm_tx_arbiter.sv
// Self-checking bench for cell_comm_tx_arbiter: directed scenarios plus random
// traffic scored against a packet-level model of the two sources.
module tb_cell_comm_tx_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 8;
    localparam int unsigned CW   = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic channel_up = 1'b1;
    logic busy, grant_fwd;
    logic [CW-1:0] local_cnt, fwd_cnt, drop_cnt, trunc_cnt;

    always #5 clk = ~clk;

    cell_comm_tx_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    cell_comm_tx_arbiter #(
        .DATA_WIDTH    (DW),
        .MAX_PKT_WORDS (MAXW),
        .COUNTER_WIDTH (CW)
    ) dut (
        .auroraUserClk    (clk),
        .auroraUserResetN (rst_n),
        .channelUp        (channel_up),
        .bus              (bus),
        .busy             (busy),
        .grantFwd         (grant_fwd),
        .localPktCount    (local_cnt),
        .fwdPktCount      (fwd_cnt),
        .dropCount        (drop_cnt),
        .truncCount       (trunc_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Model state: words each source still has to offer, and words expected on TX.
    beat_t srcq[2][$];
    beat_t expq[2][$];
    int    exp_pkt[2];
    int    exp_drop, exp_trunc;
    bit    held[2];
    bit    prev_v[2];
    int    valid_pct = 100;
    int    rdy_mode  = 0;
    bit    tog;
    int    cyc = 0;
    int    first_v_cyc[2];
    int    done_cyc;
    int    tx_beats;
    int    hs_cnt[2];
    bit    in_pkt;
    int    cur_src;
    int    order_q[$];
    bit    fwd_rdy_seen;
    bit    prev_stall;
    logic [DW-1:0] prev_data;

    function automatic void push_pkt(input int s, input int len, input bit sent, input logic [DW-1:0] base);
        int n = (len > int'(MAXW)) ? int'(MAXW) : len;
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = (base != '0) ? base + DW'(i) : DW'($urandom);
            b.last = (i == len - 1);
            srcq[s].push_back(b);
            if (sent && i < n) expq[s].push_back('{data: b.data, last: (i == n - 1)});
        end
        if (!sent)                 exp_drop++;
        else if (len > int'(MAXW)) exp_trunc++;
        else                       exp_pkt[s]++;
    endfunction

    function automatic void clear_model();
        expq[0].delete();
        expq[1].delete();
        exp_pkt[0] = 0;
        exp_pkt[1] = 0;
        exp_drop   = 0;
        exp_trunc  = 0;
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
        order_q.delete();
    endfunction

    // Source drivers and TX monitor: drive on the falling edge, observe 1 ns later.
    initial begin
        beat_t b[2];
        logic  v[2];
        logic  hs_l, hs_f, hs_t;
        int    s;
        beat_t e;
        bit    done;
        bus.localTvalid = 1'b0; bus.localTlast = 1'b0; bus.localTdata = '0;
        bus.fwdTvalid   = 1'b0; bus.fwdTlast   = 1'b0; bus.fwdTdata   = '0;
        bus.txTready    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            tog = ~tog;
            for (int k = 0; k < 2; k++) begin
                v[k] = (srcq[k].size() != 0) && (held[k] || int'($urandom_range(99)) < valid_pct);
                b[k] = v[k] ? srcq[k][0] : '0;
                if (v[k] && !prev_v[k]) first_v_cyc[k] = cyc;
                prev_v[k] = v[k];
            end
            bus.localTvalid = v[0]; bus.localTdata = b[0].data; bus.localTlast = b[0].last;
            bus.fwdTvalid   = v[1]; bus.fwdTdata   = b[1].data; bus.fwdTlast   = b[1].last;
            bus.txTready    = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'($urandom_range(1));
            #1;
            if (rst_n) begin
                hs_l = bus.localTvalid && bus.localTready;
                hs_f = bus.fwdTvalid && bus.fwdTready;
                hs_t = bus.txTvalid && bus.txTready;
                check("rdy_excl", 64'(bus.localTready && bus.fwdTready), 64'(0));
                if (!channel_up) check("tx_gated", 64'(bus.txTvalid), 64'(0));
                if (prev_stall && channel_up) begin
                    check("stall_valid", 64'(bus.txTvalid), 64'(1));
                    check("stall_data", 64'(bus.txTdata), 64'(prev_data));
                end
                if (bus.txTvalid) check("rdy_mirror", 64'(bus.localTready | bus.fwdTready), 64'(bus.txTready));
                if (hs_t) begin
                    check("hs_src", 64'(hs_l ^ hs_f), 64'(1));
                    s = hs_f ? 1 : 0;
                    if (in_pkt) check("no_interleave", 64'(s), 64'(cur_src));
                    check("tx_expected", 64'(expq[s].size() != 0), 64'(1));
                    if (expq[s].size() != 0) begin
                        e = expq[s].pop_front();
                        check("tx_data", 64'(bus.txTdata), 64'(e.data));
                        check("tx_last", 64'(bus.txTlast), 64'(e.last));
                    end
                    tx_beats++;
                    if (bus.txTlast) begin
                        in_pkt = 1'b0;
                        order_q.push_back(s);
                        done_cyc = cyc;
                    end else begin
                        in_pkt  = 1'b1;
                        cur_src = s;
                    end
                end else if (in_pkt && !channel_up) begin
                    // Partial frame is lost downstream; forget the rest of its words.
                    done = 1'b0;
                    while (!done && expq[cur_src].size() != 0) begin
                        e = expq[cur_src].pop_front();
                        done = e.last;
                    end
                    in_pkt = 1'b0;
                end
                prev_stall = bus.txTvalid && !bus.txTready && channel_up;
                prev_data  = bus.txTdata;
                if (bus.fwdTready) fwd_rdy_seen = 1'b1;
                if (hs_l) begin void'(srcq[0].pop_front()); hs_cnt[0]++; end
                if (hs_f) begin void'(srcq[1].pop_front()); hs_cnt[1]++; end
                held[0] = bus.localTvalid && !hs_l;
                held[1] = bus.fwdTvalid && !hs_f;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        srcq[0].delete();
        srcq[1].delete();
        held[0] = 1'b0;
        held[1] = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((srcq[0].size() != 0 || srcq[1].size() != 0 || busy || in_pkt) && n < 5000);
        check({tag, "_drain"}, 64'(n < 5000), 64'(1));
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (tx_beats < n && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("beat_wait", 64'(tx_beats >= n), 64'(1));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_local"}, 64'(local_cnt), 64'(exp_pkt[0]));
        check({tag, "_fwd"},   64'(fwd_cnt),   64'(exp_pkt[1]));
        check({tag, "_drop"},  64'(drop_cnt),  64'(exp_drop));
        check({tag, "_trunc"}, 64'(trunc_cnt), 64'(exp_trunc));
    endtask

    initial begin
        int hs0;
        int code;
        clear_model();
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_fwd), 64'(1));
        check("rst_txv", 64'(bus.txTvalid), 64'(0));
        check("rst_txl", 64'(bus.txTlast), 64'(0));
        check("rst_txd", 64'(bus.txTdata), 64'(0));
        check("rst_lrdy", 64'(bus.localTready), 64'(0));
        check("rst_frdy", 64'(bus.fwdTready), 64'(0));
        check_counts("rst");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // LOCAL-only 4-word packet
        fwd_rdy_seen = 1'b0;
        push_pkt(0, 4, 1'b1, 32'h11);
        wait_drain("t1");
        check("t1_latency", 64'(done_cyc - first_v_cyc[0]), 64'(4));
        check("t1_fwd_rdy", 64'(fwd_rdy_seen), 64'(0));
        check("t1_grant", 64'(grant_fwd), 64'(0));
        check_counts("t1");

        // Both sources back to back: round-robin order from reset
        apply_reset();
        push_pkt(0, 2, 1'b1, 32'hA0);
        push_pkt(0, 2, 1'b1, 32'hA2);
        push_pkt(1, 2, 1'b1, 32'hB0);
        push_pkt(1, 2, 1'b1, 32'hB2);
        wait_drain("t2");
        check("t2_npkt", 64'(order_q.size()), 64'(4));
        code = (order_q.size() == 4) ? order_q[0] * 8 + order_q[1] * 4 + order_q[2] * 2 + order_q[3] : -1;
        check("t2_rr_order", 64'(code), 64'(5));
        check_counts("t2");

        // FWD packet against a toggling txTready
        apply_reset();
        rdy_mode = 1;
        hs0 = hs_cnt[1];
        push_pkt(1, 3, 1'b1, 32'h30);
        wait_drain("t3");
        check("t3_beats", 64'(hs_cnt[1] - hs0), 64'(3));
        check_counts("t3");
        rdy_mode = 0;

        // Channel down: whole packet flushed, nothing on TX
        apply_reset();
        channel_up = 1'b0;
        hs0 = hs_cnt[0];
        push_pkt(0, 5, 1'b0, 32'h50);
        wait_drain("t4");
        check("t4_flush", 64'(hs_cnt[0] - hs0), 64'(5));
        check_counts("t4");
        channel_up = 1'b1;

        // Runaway packet truncated, then an exactly-MAX packet
        apply_reset();
        hs0 = hs_cnt[0];
        push_pkt(0, 10, 1'b1, 32'h100);
        wait_drain("t5a");
        check("t5_flush", 64'(hs_cnt[0] - hs0), 64'(10));
        check_counts("t5a");
        apply_reset();
        push_pkt(0, 8, 1'b1, 32'h180);
        wait_drain("t5b");
        check_counts("t5b");

        // Reset in the middle of a FWD packet; remainder becomes a new packet
        tx_beats = 0;
        push_pkt(1, 6, 1'b1, 32'h200);
        wait_beats(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_txv", 64'(bus.txTvalid), 64'(0));
        check("t6_frdy", 64'(bus.fwdTready), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        clear_model();
        check_counts("t6_rst");
        foreach (srcq[1][i]) expq[1].push_back(srcq[1][i]);
        exp_pkt[1] = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_drain("t6");
        check_counts("t6");

        // Channel falls mid-packet
        tx_beats = 0;
        hs0 = hs_cnt[0];
        push_pkt(0, 5, 1'b1, 32'h300);
        wait_beats(2);
        @(posedge clk);
        #2 channel_up = 1'b0;
        exp_pkt[0]--;
        exp_drop++;
        wait_drain("t7");
        check("t7_flush", 64'(hs_cnt[0] - hs0), 64'(5));
        check_counts("t7");
        @(posedge clk);
        #2 channel_up = 1'b1;

        // Random traffic with the channel up
        valid_pct = 70;
        rdy_mode  = 2;
        for (int k = 0; k < 30; k++)
            push_pkt(int'($urandom_range(1)), int'($urandom_range(11, 1)), 1'b1, '0);
        wait_drain("rnd_up");
        check_counts("rnd_up");

        // Random traffic with the channel down
        @(posedge clk);
        #2 channel_up = 1'b0;
        for (int k = 0; k < 12; k++)
            push_pkt(int'($urandom_range(1)), int'($urandom_range(11, 1)), 1'b0, '0);
        wait_drain("rnd_down");
        check_counts("rnd_down");
        channel_up = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cell_comm_tx_arbiter.md
Name: cell_comm_tx_arbiter

Overview:
- Shares one Aurora cell-comm TX AXIS link (CCW or CW; one instance per direction) between two packet sources: locally generated FA packets (LOCAL) and packets received on the opposite link being forwarded (FWD).
- Arbitrates per packet with round-robin priority.
- Drops whole packets while the channel is down.
- Truncates runaway packets and keeps wrap-around statistics for the CSR.
- Runs entirely in the Aurora user clock domain.

Parameters:
- DATA_WIDTH, 32: AXIS tdata width.
- MAX_PKT_WORDS, 64: maximum words per packet; must be ≥2. A longer packet is truncated.
- COUNTER_WIDTH, 32: width of each statistics counter.

Ports:
- auroraUserClk  in  1  Aurora user clock; all logic on its rising edge.
- auroraUserResetN  in  1  reset, asynchronous and active-low.
- channelUp  in  1  Aurora channel-up; already synchronous to auroraUserClk.
- localTvalid / localTlast  in  1 / 1  LOCAL source AXIS.
- localTdata  in  DATA_WIDTH  LOCAL source AXIS data.
- localTready  out  1  LOCAL source AXIS ready.
- fwdTvalid / fwdTlast  in  1 / 1  FWD source AXIS.
- fwdTdata  in  DATA_WIDTH  FWD source AXIS data.
- fwdTready  out  1  FWD source AXIS ready.
- txTvalid / txTlast  out  1 / 1  to Aurora TX AXIS.
- txTdata  out  DATA_WIDTH  to Aurora TX AXIS.
- txTready  in  1  from Aurora TX AXIS.
- busy  out  1  state ≠ IDLE.
- grantFwd  out  1  current or last grant: 0 = LOCAL, 1 = FWD.
- localPktCount  out  COUNTER_WIDTH  LOCAL packets completed on TX.
- fwdPktCount  out  COUNTER_WIDTH  FWD packets completed on TX.
- dropCount  out  COUNTER_WIDTH  packets discarded because the channel was down.
- truncCount  out  COUNTER_WIDTH  packets truncated at MAX_PKT_WORDS.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; grantFwd = 1, so LOCAL wins the first tie.
  - wordCnt = 0; all counters 0.
  - Outputs tx* = 0, *Tready = 0.
- States: IDLE, PASS, DISCARD. Datapath is a combinational mux on the registered grant, so PASS has 0 cycles of latency.
- IDLE:
  - No handshakes on any port.
  - If neither tvalid is high: stay in IDLE.
  - If exactly one tvalid is high: grant that source.
  - If both are high: grant the source ≠ grantFwd (round-robin).
  - Grant registers at the next edge. If channelUp = 1, go to PASS; else go to DISCARD and increment dropCount.
  - Minimum gap between packets is therefore one IDLE cycle.
- PASS:
  - txTvalid = granted tvalid; txTdata = granted tdata.
  - txTlast = granted tlast OR (wordCnt == MAX_PKT_WORDS−1).
  - Granted tready = txTready; the other source's tready = 0.
  - A beat is a handshake when txTvalid && txTready; each beat increments wordCnt.
  - Beat with source tlast = 1: increment localPktCount or fwdPktCount, wordCnt := 0, go to IDLE.
  - Beat with wordCnt == MAX−1 and source tlast = 0: forced tlast is emitted, truncCount++, wordCnt := 0, go to DISCARD to flush the source remainder.
  - A packet of exactly MAX words with tlast on word MAX counts as normal, not truncated.
  - channelUp falls while in PASS: outputs drop immediately (combinationally gated), dropCount++, wordCnt := 0, go to DISCARD. Aurora discards the partial frame.
- DISCARD:
  - txTvalid = 0; granted tready = 1; the other source's tready = 0.
  - Granted source beat with tlast: go to IDLE.
  - No timeout; a stalled source holds DISCARD.
- Counters wrap modulo 2^COUNTER_WIDTH.
- Simultaneous events:
  - If channelUp falls on the same cycle as the final tlast beat, channelUp gating wins: the packet is counted as dropped, not sent.
  - Truncation and tlast on the same beat counts as a normal completion.
- channelUp rising while in DISCARD takes effect only after that packet is flushed.
- Reset asserted mid-packet: immediately IDLE with counters cleared. The source remainder arriving after reset is treated as a new packet.

Decomposition:
- Package cell_comm_pkg holds:
  - state enum {IDLE, PASS, DISCARD};
  - source indices SRC_LOCAL = 0, SRC_FWD = 1;
  - the wordCnt width function clog2(MAX_PKT_WORDS).
- One sub-module: cell_comm_stat_counters, holding the four wrapping counters with increment strobes and async active-low reset.
- The arbiter FSM and mux stay in the top module.

Test Plan:
- LOCAL-only 4-word packet (words 0x11..0x14), txTready = 1, channelUp = 1:
  - IDLE 1 cycle, then 4 beats on TX with tlast on 0x14.
  - localPktCount = 1; fwdTready stays 0.
- Both sources continuously offer 2-word packets:
  - TX order is LOCAL, FWD, LOCAL, FWD.
  - After 4 packets, localPktCount = 2 and fwdPktCount = 2; no interleaving within a packet.
- FWD 3-word packet with txTready toggling 1,0,1,0,...:
  - fwdTready mirrors txTready; data is stable while stalled; exactly 3 beats; fwdPktCount = 1.
- channelUp = 0 with a LOCAL 5-word packet:
  - localTready = 1 for all 5 beats; txTvalid = 0 throughout; dropCount = 1; then IDLE.
- MAX_PKT_WORDS = 8 with a 10-word LOCAL packet:
  - 8 beats on TX with tlast on beat 8; 2 words flushed; truncCount = 1; localPktCount = 0.
  - An 8-word packet with tlast on word 8 instead gives localPktCount = 1 and truncCount = 0.
- Reset asserted on word 2 of a 6-word FWD packet:
  - Outputs zero immediately and counters cleared.
  - After release, the remaining 4 words are sent as a new packet: fwdPktCount = 1.
